// File: rtl/clip_pkg.sv
// Shared definitions for the multi-channel clip/saturate block.
// Holds the mode encodings and the lane limit helper.
package clip_pkg;

  localparam logic MODE_SAT  = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

  function automatic int clip_limit(
    input int bits_out,
    input bit sym,
    input bit upper
  );
    int mx;
    mx = (1 << (bits_out - 1)) - 1;
    if (upper)
      return mx;
    return sym ? -mx : -mx - 1;
  endfunction

endpackage

// File: rtl/clip_sat_lane.sv
// One combinational lane: signed reduce from BITS_IN to BITS_OUT.
// Overflow is flagged in both saturate and wrap modes.
import clip_pkg::*;

module clip_sat_lane #(
  parameter int BITS_IN   = 24,
  parameter int BITS_OUT  = 16,
  parameter int SYMMETRIC = 0
) (
  input  logic [BITS_IN-1:0]  in,
  input  logic                mode,
  output logic [BITS_OUT-1:0] out,
  output logic                ovf
);

  localparam bit SYM = (SYMMETRIC != 0);

  localparam logic signed [BITS_IN-1:0] MAXV =
    BITS_IN'(clip_limit(BITS_OUT, SYM, 1'b1));
  localparam logic signed [BITS_IN-1:0] MINV =
    BITS_IN'(clip_limit(BITS_OUT, SYM, 1'b0));

  logic hi;
  logic lo;
  logic sat;

  assign hi  = $signed(in) > MAXV;
  assign lo  = $signed(in) < MINV;
  assign ovf = hi | lo;
  assign sat = (mode == MODE_SAT);

  always_comb begin
    out = in[BITS_OUT-1:0];
    unique case (1'b1)
      sat && hi: out = MAXV[BITS_OUT-1:0];
      sat && lo: out = MINV[BITS_OUT-1:0];
      default:   out = in[BITS_OUT-1:0];
    endcase
  end

endmodule

// File: rtl/clip_sat_multi.sv
// NCH-lane registered clipper with sticky overflow flags
// and a saturating clip-event counter.
import clip_pkg::*;

module clip_sat_multi #(
  parameter int NCH         = 2,
  parameter int BITS_IN     = 24,
  parameter int BITS_OUT    = 16,
  parameter int SYMMETRIC   = 0,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stb_in,
  input  logic [NCH*BITS_IN-1:0]  in,
  input  logic                    mode,
  input  logic                    clear,
  output logic                    stb_out,
  output logic [NCH*BITS_OUT-1:0] out,
  output logic [NCH-1:0]          ovf_sticky,
  output logic [COUNT_WIDTH-1:0]  clip_count
);

  localparam logic [COUNT_WIDTH-1:0] CMAX = '1;

  logic [NCH*BITS_OUT-1:0] lane_out;
  logic [NCH-1:0]          lane_ovf;
  logic [NCH-1:0]          ev;
  logic                    any_ev;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    clip_sat_lane #(
      .BITS_IN  (BITS_IN),
      .BITS_OUT (BITS_OUT),
      .SYMMETRIC(SYMMETRIC)
    ) u_lane (
      .in  (in[k*BITS_IN +: BITS_IN]),
      .mode(mode),
      .out (lane_out[k*BITS_OUT +: BITS_OUT]),
      .ovf (lane_ovf[k])
    );
  end

  assign ev     = stb_in ? lane_ovf : '0;
  assign any_ev = |ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_out <= 1'b0;
      out     <= '0;
    end else begin
      stb_out <= stb_in;
      if (stb_in)
        out <= lane_out;
    end
  end

  // A clear coincident with an event keeps that event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= '0;
      clip_count <= '0;
    end else if (clear) begin
      ovf_sticky <= ev;
      clip_count <= any_ev ? COUNT_WIDTH'(1) : '0;
    end else begin
      ovf_sticky <= ovf_sticky | ev;
      if (any_ev && clip_count != CMAX)
        clip_count <= clip_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_clip_sat_multi.sv
// Bench for clip_sat_multi: asymmetric and symmetric builds
// driven in parallel, checked against a behavioural model.
module tb_clip_sat_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb_in = 1'b0;
  logic [15:0] din = '0;
  logic        mode = 1'b0;
  logic        clear = 1'b0;

  logic       so0, so1;
  logic [7:0] q0, q1;
  logic [1:0] st0, st1;
  logic [1:0] cn0, cn1;

  int n = 0;
  int errs = 0;

  int exp_out [2][2];
  int exp_stb;
  int exp_st [2];
  int exp_cn [2];

  always #5 clk = ~clk;

  clip_sat_multi #(
    .NCH(2), .BITS_IN(8), .BITS_OUT(4),
    .SYMMETRIC(0), .COUNT_WIDTH(2)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .stb_in(stb_in),
    .in(din), .mode(mode), .clear(clear),
    .stb_out(so0), .out(q0),
    .ovf_sticky(st0), .clip_count(cn0)
  );

  clip_sat_multi #(
    .NCH(2), .BITS_IN(8), .BITS_OUT(4),
    .SYMMETRIC(1), .COUNT_WIDTH(2)
  ) u_s (
    .clk(clk), .rst_n(rst_n), .stb_in(stb_in),
    .in(din), .mode(mode), .clear(clear),
    .stb_out(so1), .out(q1),
    .ovf_sticky(st1), .clip_count(cn1)
  );

  task automatic model_reset();
    exp_stb = 0;
    for (int d = 0; d < 2; d++) begin
      exp_st[d] = 0;
      exp_cn[d] = 0;
      exp_out[d][0] = 0;
      exp_out[d][1] = 0;
    end
  endtask

  function automatic int ref_lane(
    input int v, input bit m, input bit sym,
    output bit ov
  );
    int mx, mn, o;
    mx = 7;
    mn = sym ? -7 : -8;
    ov = (v > mx) || (v < mn);
    o = v;
    if (!m && v > mx) o = mx;
    if (!m && v < mn) o = mn;
    return o & 15;
  endfunction

  task automatic cyc(
    input bit s, input logic [7:0] a, input logic [7:0] b,
    input bit m, input bit c
  );
    int v [2];
    bit ov;
    int mask;
    int got_o, got_st, got_cn, got_s;
    stb_in = s;
    din = {b, a};
    mode = m;
    clear = c;
    v[0] = int'($signed(a));
    v[1] = int'($signed(b));
    @(posedge clk);
    exp_stb = s;
    for (int d = 0; d < 2; d++) begin
      mask = 0;
      for (int k = 0; k < 2; k++) begin
        int o;
        o = ref_lane(v[k], m, d[0], ov);
        if (s) exp_out[d][k] = o;
        if (s && ov) mask |= (1 << k);
      end
      if (c) begin
        exp_st[d] = mask;
        exp_cn[d] = (mask != 0) ? 1 : 0;
      end else begin
        exp_st[d] |= mask;
        if (mask != 0 && exp_cn[d] < 3) exp_cn[d]++;
      end
    end
    #1;
    stb_in = 1'b0;
    clear = 1'b0;
    for (int d = 0; d < 2; d++) begin
      int eo;
      eo = exp_out[d][0] | (exp_out[d][1] << 4);
      got_o  = int'(d == 0 ? q0 : q1);
      got_s  = int'(d == 0 ? so0 : so1);
      got_st = int'(d == 0 ? st0 : st1);
      got_cn = int'(d == 0 ? cn0 : cn1);
      n++;
      if (got_o !== eo) begin
        errs++;
        $display("FAIL out dut%0d got %h want %h", d, got_o, eo);
      end
      n++;
      if (got_s !== exp_stb) begin
        errs++;
        $display("FAIL stb_out dut%0d got %0d want %0d",
                 d, got_s, exp_stb);
      end
      n++;
      if (got_st !== exp_st[d]) begin
        errs++;
        $display("FAIL sticky dut%0d got %b want %b",
                 d, got_st, exp_st[d]);
      end
      n++;
      if (got_cn !== exp_cn[d]) begin
        errs++;
        $display("FAIL count dut%0d got %0d want %0d",
                 d, got_cn, exp_cn[d]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n++;
    if ({so0, q0, st0, cn0, so1, q1, st1, cn1} !== '0) begin
      errs++;
      $display("FAIL reset_state got %h want 0",
               {so0, q0, st0, cn0, so1, q1, st1, cn1});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_saturate();
    cyc(0, 8'h00, 8'h00, 0, 1);
    cyc(1, 8'h05, 8'h7F, 0, 0);
    n++;
    if ({q0, st0, cn0} !== {8'h75, 2'b10, 2'd1}) begin
      errs++;
      $display("FAIL sat_basic got %h/%b/%0d want 75/10/1",
               q0, st0, cn0);
    end
    cyc(1, 8'h80, 8'h00, 0, 1);
    n++;
    if (q0[3:0] !== 4'h8 || q1[3:0] !== 4'h9) begin
      errs++;
      $display("FAIL sat_neg got %h,%h want 8,9",
               q0[3:0], q1[3:0]);
    end
    cyc(1, 8'hF8, 8'h00, 0, 1);
    n++;
    if (q0[3:0] !== 4'h8 || st0 !== 2'b00) begin
      errs++;
      $display("FAIL sat_min_edge got %h/%b want 8/00",
               q0[3:0], st0);
    end
  endtask

  task automatic test_wrap();
    cyc(0, 8'h00, 8'h00, 0, 1);
    cyc(1, 8'h03, 8'h7F, 1, 0);
    n++;
    if ({q0, st0, cn0} !== {8'hF3, 2'b10, 2'd1}) begin
      errs++;
      $display("FAIL wrap got %h/%b/%0d want f3/10/1",
               q0, st0, cn0);
    end
  endtask

  task automatic test_count_sat();
    cyc(0, 8'h00, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++)
      cyc(1, 8'h40, 8'hC0, 0, 0);
    cyc(0, 8'h00, 8'h00, 0, 1);
    n++;
    if (cn0 !== 2'd0 || st0 !== 2'b00) begin
      errs++;
      $display("FAIL clear got %0d/%b want 0/00", cn0, st0);
    end
    cyc(1, 8'h40, 8'h01, 0, 0);
    cyc(1, 8'h90, 8'h02, 0, 1);
    n++;
    if (cn0 !== 2'd1 || st0 !== 2'b01) begin
      errs++;
      $display("FAIL clear_event got %0d/%b want 1/01",
               cn0, st0);
    end
  endtask

  task automatic test_gaps();
    cyc(1, 8'h12, 8'h34, 0, 0);
    cyc(0, 8'h55, 8'hAA, 1, 0);
    n++;
    if (so0 !== 1'b0) begin
      errs++;
      $display("FAIL gap_stb got %b want 0", so0);
    end
    cyc(0, 8'h7F, 8'h80, 0, 0);
    cyc(1, 8'h01, 8'hFE, 0, 0);
  endtask

  task automatic test_midreset();
    cyc(0, 8'h00, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++)
      cyc(1, 8'h7F, 8'h00, 0, 0);
    rst_n = 1'b0;
    #1;
    n++;
    if ({so0, q0, st0, cn0} !== '0) begin
      errs++;
      $display("FAIL midreset got %h want 0",
               {so0, q0, st0, cn0});
    end
    model_reset();
    @(posedge clk);
    #1;
    n++;
    if (so0 !== 1'b0 || so1 !== 1'b0) begin
      errs++;
      $display("FAIL midreset_stb got %b%b want 00", so0, so1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 8'h02, 8'h01, 0, 0);
    cyc(0, 8'h00, 8'h00, 0, 0);
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 0) a = 8'($urandom_range(0, 15) - 8);
      if ($urandom_range(0, 1) == 0) b = 8'($urandom_range(0, 15) - 8);
      cyc($urandom_range(0, 3) != 0, a, b,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_wrap();
    test_count_sat();
    test_gaps();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             n, errs);
    $finish;
  end

endmodule

// File: doc/clip_sat_multi.md
Name: clip_sat_multi

Overview:
- Parametrised, multi-channel successor to the single-lane registered clipper.
- Reduces NCH signed samples of BITS_IN each to BITS_OUT each, under a strobe (stb) qualifier.
- Runtime mode selects saturate or wrap; optional symmetric saturation limits.
- Per-channel sticky overflow flags and a saturating clip-event counter give software visibility.
- Sits between DDC/DUC arithmetic stages and the sample FIFOs or output buses.

Parameters:
- NCH, 2: number of channels packed on the input/output buses.
- BITS_IN, 24: signed input width per channel.
- BITS_OUT, 16: signed output width per channel; must satisfy BITS_OUT < BITS_IN.
- SYMMETRIC, 0: 0 sets the negative limit to -2^(BITS_OUT-1); 1 sets it to -(2^(BITS_OUT-1)-1).
- COUNT_WIDTH, 16: width of the clip-event counter.

Ports:
- clk, input, 1: sole clock; all logic on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- stb_in, input, 1: input samples valid this cycle.
- in, input, NCH*BITS_IN: channel k occupies bits [k*BITS_IN +: BITS_IN]; channel 0 is at the LSBs.
- mode, input, 1: 0 = saturate, 1 = wrap (keep the bottom BITS_OUT bits). Sampled on stb_in cycles.
- clear, input, 1: synchronous clear of the sticky flags and the counter.
- stb_out, output, 1: output samples valid.
- out, output, NCH*BITS_OUT: packed the same way as in.
- ovf_sticky, output, NCH: per-channel overflow seen since the last clear or reset.
- clip_count, output, COUNT_WIDTH: number of stb_in cycles in which any channel overflowed.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately): out=0, stb_out=0, ovf_sticky=0, clip_count=0. Release is synchronous to clk; the first accepted sample is on the first rising edge with rst_n high.
- Per-lane limits: MAX = 2^(BITS_OUT-1)-1. MIN = -2^(BITS_OUT-1), or -MAX when SYMMETRIC=1.
- Overflow for lane k: in_k > MAX or in_k < MIN. It is a signed comparison over the full BITS_IN.
- Saturate mode: out_k = MAX if in_k > MAX; MIN if in_k < MIN; otherwise in_k[BITS_OUT-1:0].
- Wrap mode: out_k = in_k[BITS_OUT-1:0] unconditionally. Overflow is still detected, flagged and counted.
- Latency: exactly 1 cycle. stb_out is stb_in registered. out updates only on stb_in cycles and holds its value otherwise.
- The block accepts one sample per cycle with no backpressure; back-to-back strobes are supported.
- ovf_sticky[k] is set on the cycle after an stb_in cycle in which lane k overflowed. It remains set until clear or reset.
- clip_count increments by 1 per stb_in cycle with any lane overflow, regardless of how many lanes overflowed. It saturates at 2^COUNT_WIDTH-1 and never wraps.
- Clear with no event in the same cycle: ovf_sticky=0 and clip_count=0 next cycle.
- Clear coincident with an overflow event: the event is not lost. Next cycle clip_count=1 and only the overflowing lanes' sticky bits are set.
- Inputs are ignored and counters hold while stb_in=0.
- A mode change takes effect on the next stb_in sample; there is no pipeline flush.
- Reset asserted mid-stream: all state is dropped and outputs zero immediately. The pipeline word in flight is discarded; no stb_out follows.

Decomposition:
- Package clip_pkg holds the mode encodings (MODE_SAT=1'b0, MODE_WRAP=1'b1) and a function computing MAX/MIN from BITS_OUT and SYMMETRIC.
- One natural combinational sub-module, clip_sat_lane (BITS_IN, BITS_OUT, SYMMETRIC): in, mode -> out, ovf. It is instantiated NCH times in a generate loop.
- The top level holds the output register, strobe pipeline, sticky flags and counter.

Test Plan:
- NCH=2, BITS_IN=8, BITS_OUT=4, SYMMETRIC=0, saturate mode. Strobe ch0=0x05, ch1=0x7F -> next cycle stb_out=1, out ch0=0x5, ch1=0x7; ovf_sticky=2'b10; clip_count=1.
- Same configuration, ch0=0x80 (-128) -> out ch0=0x8 (-8). Rebuild with SYMMETRIC=1 -> out ch0=0x9 (-7). ch0=0xF8 (-8) -> 0x8, no overflow (SYMMETRIC=0).
- Wrap mode, ch1=0x7F -> out ch1=0xF, ovf_sticky[1]=1, clip_count increments. ch0=0x03 -> 0x3, no flag.
- COUNT_WIDTH=2, five consecutive overflowing strobes -> clip_count sequence 1,2,3,3,3. Then clear with no event -> count=0, ovf_sticky=0. Then clear coincident with a ch0 overflow -> count=1, ovf_sticky=2'b01.
- Strobe gaps: stb_in pattern 1,0,0,1 -> stb_out follows one cycle later; out holds between strobes; counter unchanged on idle cycles.
- Reset mid-stream: drop rst_n between clock edges while stb_out=1 and count=3 -> out, stb_out, ovf_sticky, clip_count are 0 before the next edge. After release, the first strobe produces its result one cycle later.
